des_round_seq: RTL

- Iterative DES sequencer: accepts one 64-bit block plus 64-bit key, runs 16 Feistel rounds, returns the 64-bit result.
- Owns the datapath registers (L/R halves, C/D key halves), IP/FP, PC-1/PC-2, key-schedule shifts and the round counter.
- Time-shares one external f-function (E-expansion, key XOR, S_Box_1..S_Box_8, P) over all 16 rounds.
- Sits between the stream framer and the shared f-function instance.

---
 rtl/des_round_seq.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/des_round_seq.sv
// Iterative DES sequencer: IP/FP, PC-1/PC-2, key-schedule rotations and a 16-round
// Feistel loop that time-shares one external f-function (E, key XOR, S-boxes, P).
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_data/in_key/in_decrypt
// accept a block; f_r/f_subkey go out to the f-function, f_result comes back
// combinationally; round_idx shows the current round; out_valid/out_ready/out_data
// return FP(R16||L16). Bit 63 of every 64-bit bus is DES bit 1.
// Optional macro DES_FRESULT_REG_EN registers f_result (two cycles per round).
module des_round_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic [63:0] in_key,
    input  logic        in_decrypt,
    output logic [31:0] f_r,
    output logic [47:0] f_subkey,
    input  logic [31:0] f_result,
    output logic [3:0]  round_idx,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data
);

    localparam int IP_T [0:63] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7
    };

    localparam int FP_T [0:63] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25
    };

    localparam int PC1_T [0:55] = '{
        57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
        10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
        14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4
    };

    localparam int PC2_T [0:47] = '{
        14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
        23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // Tables are 1-based DES bit numbers; DES bit n lives at x[W-n].
    function automatic logic [63:0] perm_ip(input logic [63:0] x);
        for (int i = 0; i < 64; i++) perm_ip[63-i] = x[64-IP_T[i]];
    endfunction

    function automatic logic [63:0] perm_fp(input logic [63:0] x);
        for (int i = 0; i < 64; i++) perm_fp[63-i] = x[64-FP_T[i]];
    endfunction

    function automatic logic [55:0] perm_pc1(input logic [63:0] x);
        for (int i = 0; i < 56; i++) perm_pc1[55-i] = x[64-PC1_T[i]];
    endfunction

    function automatic logic [47:0] perm_pc2(input logic [55:0] x);
        for (int i = 0; i < 48; i++) perm_pc2[47-i] = x[56-PC2_T[i]];
    endfunction

`ifdef DES_FRESULT_REG_EN
    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE, S_FWAIT} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_t;
`endif

    state_t      state;
    logic [31:0] l;
    logic [31:0] r;
    logic [27:0] c;
    logic [27:0] d;
    logic [3:0]  cnt;
    logic        dec;
    logic [27:0] c_rot;
    logic [27:0] d_rot;
    logic        one_shift;
    logic [31:0] f_use;

`ifdef DES_FRESULT_REG_EN
    logic [31:0] f_q;
    assign f_use = f_q;
`else
    assign f_use = f_result;
`endif

    assign one_shift = (cnt == 4'd0) || (cnt == 4'd1) ||
                       (cnt == 4'd8) || (cnt == 4'd15);

    // Rotation sits ahead of PC-2 so the subkey is ready in the round's own cycle.
    // Decrypt round 0 uses C0/D0 as-is: its subkey equals encrypt round 15's.
    always_comb begin
        c_rot = c;
        d_rot = d;
        if (!dec) begin
            if (one_shift) begin
                c_rot = {c[26:0], c[27]};
                d_rot = {d[26:0], d[27]};
            end else begin
                c_rot = {c[25:0], c[27:26]};
                d_rot = {d[25:0], d[27:26]};
            end
        end else if (cnt != 4'd0) begin
            if (one_shift) begin
                c_rot = {c[0], c[27:1]};
                d_rot = {d[0], d[27:1]};
            end else begin
                c_rot = {c[1:0], c[27:2]};
                d_rot = {d[1:0], d[27:2]};
            end
        end
    end

    assign f_r       = r;
    assign f_subkey  = perm_pc2({c_rot, d_rot});
    assign round_idx = cnt;
    assign in_ready  = (state == S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            l         <= '0;
            r         <= '0;
            c         <= '0;
            d         <= '0;
            cnt       <= '0;
            dec       <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
`ifdef DES_FRESULT_REG_EN
            f_q       <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        {l, r} <= perm_ip(in_data);
                        {c, d} <= perm_pc1(in_key);
                        dec    <= in_decrypt;
                        cnt    <= 4'd0;
                        state  <= S_ROUND;
                    end
                end
`ifdef DES_FRESULT_REG_EN
                S_ROUND: begin
                    f_q   <= f_result;
                    state <= S_FWAIT;
                end
                S_FWAIT: begin
`else
                S_ROUND: begin
`endif
                    l   <= r;
                    r   <= l ^ f_use;
                    c   <= c_rot;
                    d   <= d_rot;
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        // Final halves are swapped before FP: R16 || L16.
                        out_data  <= perm_fp({l ^ f_use, r});
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        state <= S_ROUND;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
